// File: rtl/corelet_ctrl.sv
// Sequencer for one corelet (L0 + MAC array + OFIFO) in the weight-stationary flow.
// Every output is a register loaded from a decode of the next state, so each output changes on a clock edge.
//
// state  | meaning
// IDLE   | waiting for start
// LDW    | read col weight words from xmem into L0 (L0 write lags the read by 1)
// KLD    | kernel load from L0 into the array, then KGAP settle cycles
// LDX    | read num_x activation vectors from xmem into L0
// EXE    | stream activations through the array
// DRN    | wait for the first OFIFO row
// RD     | pop OFIFO rows and write them to pmem one cycle later
// DONE   | one-cycle completion pulse
module corelet_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int ADDR_W = 11,
    parameter int W_BASE = 1024,
    parameter int KGAP   = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_kij,
    input  logic [CNT_W-1:0]  num_x,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              xw_mode,
    output logic              sfp_reset,
    output logic              xmem_cen,
    output logic [ADDR_W-1:0] xmem_addr,
    output logic              pmem_wen,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LDW, S_KLD, S_LDX, S_EXE, S_DRN, S_RD, S_DONE
    } state_t;

    // The phase counter only has to span the longest fixed phase or a full L0 of activations.
    localparam int SEQ_MAX = (col + KGAP > row + 1) ? (col + KGAP) : (row + 1);
    localparam int CW      = $clog2(SEQ_MAX + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   kij_q, kij_d;
    logic [CNT_W-1:0]   nk_q, nk_d;
    logic [CNT_W-1:0]   nx_q, nx_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               rd_now_q, rd_now_d;
    logic               wr_now_q, wr_now_d;
    logic [ADDR_W-1:0]  wbase_q, wbase_d;
    logic [ADDR_W-1:0]  pptr_q, pptr_d;

    logic [33:0]        inst_d;
    logic               xw_mode_d;
    logic               xmem_cen_d;
    logic [ADDR_W-1:0]  xmem_addr_d;
    logic               pmem_wen_d;
    logic [ADDR_W-1:0]  pmem_addr_d;
    logic               busy_d;
    logic               done_d;
    logic               last_wr;
    logic               more_kij;

    assign last_wr  = wr_now_q && ((wr_cnt_q + CNT_W'(1)) == nx_q);
    assign more_kij = ({1'b0, kij_q} + (CNT_W+1)'(1)) < {1'b0, nk_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kij_d    = kij_q;
        nk_d     = nk_q;
        nx_d     = nx_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q + CNT_W'(wr_now_q);
        rd_now_d = 1'b0;
        wr_now_d = rd_now_q;
        wbase_d  = wbase_q;
        pptr_d   = pptr_q + ADDR_W'(wr_now_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nk_d    = num_kij;
                    nx_d    = num_x;
                    kij_d   = '0;
                    cnt_d   = '0;
                    wbase_d = ADDR_W'(W_BASE);
                    pptr_d  = '0;
                    if (num_kij == '0 || num_x == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LDW;
                    end
                end
            end
            S_LDW: begin
                if (int'(cnt_q) == col) begin
                    state_d = S_KLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_KLD: begin
                if (int'(cnt_q) == col + KGAP - 1) begin
                    state_d = S_LDX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LDX: begin
                if (int'(cnt_q) == int'(nx_q)) begin
                    state_d = S_EXE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXE: begin
                if (int'(cnt_q) == int'(nx_q) - 1) begin
                    state_d  = S_DRN;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRN: begin
                if (ofifo_valid) begin
                    state_d  = S_RD;
                    rd_now_d = 1'b1;
                    rd_cnt_d = CNT_W'(1);
                end
            end
            S_RD: begin
                if (ofifo_valid && (rd_cnt_q < nx_q)) begin
                    rd_now_d = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (last_wr) begin
                    if (more_kij) begin
                        state_d = S_LDW;
                        kij_d   = kij_q + CNT_W'(1);
                        cnt_d   = '0;
                        wbase_d = wbase_q + ADDR_W'(col);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode looks at the next-cycle state so the registered outputs line up with it.
    always_comb begin
        inst_d      = '0;
        xw_mode_d   = 1'b0;
        xmem_cen_d  = 1'b1;
        xmem_addr_d = '0;
        pmem_wen_d  = 1'b1;
        pmem_addr_d = '0;
        case (state_d)
            S_LDW: begin
                xw_mode_d = 1'b1;
                if (int'(cnt_d) < col) begin
                    xmem_cen_d  = 1'b0;
                    xmem_addr_d = wbase_d + ADDR_W'(cnt_d);
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_KLD: begin
                xw_mode_d = 1'b1;
                if (int'(cnt_d) < col) begin
                    inst_d[3] = 1'b1;
                    inst_d[0] = 1'b1;
                end
            end
            S_LDX: begin
                if (int'(cnt_d) < int'(nx_d)) begin
                    xmem_cen_d  = 1'b0;
                    xmem_addr_d = ADDR_W'(cnt_d);
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_EXE: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_RD: begin
                inst_d[6] = rd_now_d;
                if (wr_now_d) begin
                    pmem_wen_d  = 1'b0;
                    pmem_addr_d = pptr_d;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            kij_q     <= '0;
            nk_q      <= '0;
            nx_q      <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_now_q  <= 1'b0;
            wr_now_q  <= 1'b0;
            wbase_q   <= '0;
            pptr_q    <= '0;
            inst      <= '0;
            xw_mode   <= 1'b0;
            sfp_reset <= 1'b1;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kij_q     <= kij_d;
            nk_q      <= nk_d;
            nx_q      <= nx_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_now_q  <= rd_now_d;
            wr_now_q  <= wr_now_d;
            wbase_q   <= wbase_d;
            pptr_q    <= pptr_d;
            inst      <= inst_d;
            xw_mode   <= xw_mode_d;
            sfp_reset <= !busy_d;
            xmem_cen  <= xmem_cen_d;
            xmem_addr <= xmem_addr_d;
            pmem_wen  <= pmem_wen_d;
            pmem_addr <= pmem_addr_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: hand-computed cycle counts, address sequences and handshake tables.
module tb_corelet_ctrl;

    localparam int WB   = 1024;
    localparam int COLN = 8;
    localparam int GAP  = 8;
    localparam logic [33:0] OTHER_MASK = ~34'h4F;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  num_kij;
    logic [7:0]  num_x;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        xw_mode;
    logic        sfp_reset;
    logic        xmem_cen;
    logic [10:0] xmem_addr;
    logic        pmem_wen;
    logic [10:0] pmem_addr;
    logic        busy;
    logic        done;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_kij(num_kij), .num_x(num_x),
        .ofifo_valid(ofifo_valid), .inst(inst), .xw_mode(xw_mode), .sfp_reset(sfp_reset),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int xq[$], pq[$], exp_x[$], exp_p[$];
    int n0, n1, n6, nother, nlag, nxw, nxwbad, nbusy, nsfp, ndone, done_cyc;
    int post_done, post_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_inst"}, 64'(inst), 64'd0);
        check({tag, "_xw_mode"}, 64'(xw_mode), 64'd0);
        check({tag, "_sfp_reset"}, 64'(sfp_reset), 64'd1);
        check({tag, "_xmem_cen"}, 64'(xmem_cen), 64'd1);
        check({tag, "_pmem_wen"}, 64'(pmem_wen), 64'd1);
        check({tag, "_addrs"}, 64'({xmem_addr, pmem_addr}), 64'd0);
        check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
    endtask

    task automatic build_expected(input int nk, input int nx);
        exp_x.delete();
        exp_p.delete();
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i < COLN; i++) exp_x.push_back(WB + k * COLN + i);
            for (int j = 0; j < nx; j++) exp_x.push_back(j);
        end
        for (int j = 0; j < nk * nx; j++) exp_p.push_back(j);
    endtask

    task automatic check_lists(input string tag);
        int bad;
        check({tag, "_xread_count"}, 64'(xq.size()), 64'(exp_x.size()));
        bad = 0;
        for (int i = 0; i < xq.size() && i < exp_x.size(); i++) if (xq[i] != exp_x[i]) bad++;
        check({tag, "_xaddr_seq_errors"}, 64'(bad), 64'd0);
        check({tag, "_pwrite_count"}, 64'(pq.size()), 64'(exp_p.size()));
        bad = 0;
        for (int i = 0; i < pq.size() && i < exp_p.size(); i++) if (pq[i] != exp_p[i]) bad++;
        check({tag, "_paddr_seq_errors"}, 64'(bad), 64'd0);
    endtask

    // Caller sets inputs and raises start; this drops start after the first edge,
    // scrambles num_* (latched values must be used), optionally re-pulses start mid-run.
    task automatic run(input int max_cyc, input int restart_at);
        int cyc;
        bit seen, prev_rd;
        xq.delete(); pq.delete();
        n0 = 0; n1 = 0; n6 = 0; nother = 0; nlag = 0; nxw = 0; nxwbad = 0;
        nbusy = 0; nsfp = 0; ndone = 0; done_cyc = -1; post_done = 0; post_busy = 0;
        cyc = 0; seen = 0; prev_rd = 0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) begin
                num_kij = 8'd1;
                num_x   = 8'd1;
            end
            if (!xmem_cen) xq.push_back(int'(xmem_addr));
            if (!pmem_wen) pq.push_back(int'(pmem_addr));
            if (inst[0]) n0++;
            if (inst[1]) n1++;
            if (inst[6]) n6++;
            if ((inst & OTHER_MASK) != '0) nother++;
            if (inst[2] !== prev_rd) nlag++;
            prev_rd = !xmem_cen;
            if (xw_mode) nxw++;
            if (!xmem_cen && (xw_mode != (xmem_addr >= 11'(WB)))) nxwbad++;
            if (!busy) nbusy++;
            if (sfp_reset !== !busy) nsfp++;
            if (done) begin
                seen = 1;
                ndone++;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        repeat (2) begin
            tick();
            if (done) post_done++;
            if (busy) post_busy++;
        end
    endtask

    task automatic check_run(input string tag, input int nk, input int nx, input int exp_done);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_done_pulses"}, 64'(ndone + post_done), 64'd1);
        check({tag, "_busy_after_done"}, 64'(post_busy), 64'd0);
        check({tag, "_kernel_load_cycles"}, 64'(n0), 64'(nk * COLN));
        check({tag, "_execute_cycles"}, 64'(n1), 64'(nk * nx));
        check({tag, "_ofifo_rd_cycles"}, 64'(n6), 64'(nk * nx));
        check({tag, "_stray_inst_bits"}, 64'(nother), 64'd0);
        check({tag, "_l0wr_lag_errors"}, 64'(nlag), 64'd0);
        check({tag, "_xw_mode_cycles"}, 64'(nxw), 64'(nk * (2 * COLN + 1 + GAP)));
        check({tag, "_xw_mode_vs_addr"}, 64'(nxwbad), 64'd0);
        check({tag, "_busy_gaps"}, 64'(nbusy), 64'd0);
        check({tag, "_sfp_reset_errors"}, 64'(nsfp), 64'd0);
        build_expected(nk, nx);
        check_lists(tag);
    endtask

    int vpat[7]  = '{1, 0, 0, 1, 1, 1, 1};
    int e_rd[7]  = '{1, 0, 0, 1, 1, 0, 0};
    int e_wen[7] = '{1, 0, 1, 1, 0, 0, 1};
    int e_pa[7]  = '{0, 0, 0, 0, 1, 2, 0};
    int e_dn[7]  = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        int nwr;
        reset = 1'b0; start = 1'b0; num_kij = '0; num_x = '0; ofifo_valid = 1'b0;
        repeat (2) tick();
        check_reset_vals("por");
        reset = 1'b1;
        tick();
        check_reset_vals("idle");

        // One kij, four activation vectors, OFIFO always ready: done 40 cycles of work + DONE.
        ofifo_valid = 1'b1; num_kij = 8'd1; num_x = 8'd4; start = 1'b1;
        run(200, 0);
        check_run("s1", 1, 4, 41);

        // Three kij, two vectors; a second start mid-run must be ignored.
        num_kij = 8'd3; num_x = 8'd2; start = 1'b1;
        run(400, 20);
        check_run("s2", 3, 2, 103);

        // OFIFO throttling during drain/read, three vectors.
        ofifo_valid = 1'b0; num_kij = 8'd1; num_x = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (33) tick();
        check("drn_wait_inst", 64'(inst), 64'd0);
        check("drn_wait_wen_busy", 64'({pmem_wen, busy}), 64'd3);
        nwr = 0;
        for (int i = 0; i < 7; i++) begin
            ofifo_valid = vpat[i][0];
            tick();
            check($sformatf("thr_rd_%0d", i), 64'(inst[6]), 64'(e_rd[i]));
            check($sformatf("thr_wen_%0d", i), 64'(pmem_wen), 64'(e_wen[i]));
            if (e_wen[i] == 0) check($sformatf("thr_paddr_%0d", i), 64'(pmem_addr), 64'(e_pa[i]));
            check($sformatf("thr_done_%0d", i), 64'(done), 64'(e_dn[i]));
            if (!pmem_wen) nwr++;
        end
        check("thr_write_count", 64'(nwr), 64'd3);
        tick();
        check("thr_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of EXE.
        ofifo_valid = 1'b1; num_kij = 8'd2; num_x = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        check("exe_before_abort", 64'({inst[3], inst[1]}), 64'd3);
        #2 reset = 1'b0;
        #1 check_reset_vals("abort");
        tick();
        reset = 1'b1;
        tick();
        num_kij = 8'd1; num_x = 8'd4; start = 1'b1;
        run(200, 0);
        check_run("rerun", 1, 4, 41);

        // Zero counts finish immediately with no memory traffic.
        num_kij = 8'd2; num_x = 8'd0; start = 1'b1;
        run(10, 0);
        check("zx_done_cycle", 64'(done_cyc), 64'd1);
        check("zx_mem_activity", 64'(xq.size() + pq.size()), 64'd0);
        check("zx_post", 64'({post_done, post_busy}), 64'd0);
        num_kij = 8'd0; num_x = 8'd3; start = 1'b1;
        run(10, 0);
        check("zk_done_cycle", 64'(done_cyc), 64'd1);
        check("zk_mem_activity", 64'(xq.size() + pq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
